// File: rtl/alu_op_sequencer_if.sv
// Command/result handshake between the ALU op sequencer (master) and its
// ALU/register responder (slave).
interface alu_op_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_func;
  logic [3:0] op_a;
  logic       res_valid;
  logic [7:0] res_data;

  modport master (
    output op_valid, op_func, op_a,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_func, op_a,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Steps through a small program of {func, operand} entries, issuing each to an ALU responder.
// Optional WAIT timeout with sticky error flag: define ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [6:0]          prog_data,
  input  logic [AW-1:0]       prog_last,
  input  logic                start,
  alu_op_sequencer_if.master  op_if,
  output logic                busy,
  output logic                done,
  output logic [7:0]          result,
  output logic [3:0]          zero_cnt,
  output logic                error
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [6:0]    r_mem [DEPTH];
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_last;
  logic [7:0]    r_result;
  logic [3:0]    r_zero;
  logic [6:0]    w_entry;
  logic          w_tmo_hit;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [3:0] r_tmo;
  logic       r_error;
  // Counter holds k-1 during the k-th WAIT cycle, so 14 marks the 15th idle cycle.
  assign w_tmo_hit = (r_tmo == 4'd14);
  assign error     = r_error;
`else
  assign w_tmo_hit = 1'b0;
  assign error     = 1'b0;
`endif

  assign w_entry = r_mem[r_pc];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: if (op_if.op_ready) w_next = S_WAIT;
      S_WAIT: begin
        if (op_if.res_valid) w_next = (r_pc == r_last) ? S_DONE : S_ISSUE;
        else if (w_tmo_hit)  w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command fields are forced to zero outside ISSUE so reset never exposes unreset memory.
  assign op_if.op_valid = (r_state == S_ISSUE);
  assign op_if.op_func  = (r_state == S_ISSUE) ? w_entry[6:4] : '0;
  assign op_if.op_a     = (r_state == S_ISSUE) ? w_entry[3:0] : '0;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign result         = r_result;
  assign zero_cnt       = r_zero;

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && prog_we) r_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= '0;
      r_last   <= '0;
      r_result <= '0;
      r_zero   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      r_tmo    <= '0;
      r_error  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc   <= '0;
            r_last <= prog_last;
            r_zero <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_error <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
`ifdef ALU_SEQ_TIMEOUT_EN
          r_tmo <= '0;
`endif
        end
        S_WAIT: begin
          if (op_if.res_valid) begin
            r_result <= op_if.res_data;
            if (op_if.res_data == 8'h00 && r_zero != 4'hF) r_zero <= r_zero + 4'd1;
            r_pc <= r_pc + AW'(1);
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (w_tmo_hit) r_error <= 1'b1;
          else                r_tmo   <= r_tmo + 4'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of program runs plus hand-written corner sequences.
module tb_alu_op_sequencer;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [6:0] prog_data;
  logic [2:0] prog_last;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] zero_cnt;
  logic       error;

  alu_op_sequencer_if u_if ();

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_last (prog_last),
    .start     (start),
    .op_if     (u_if),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero_cnt  (zero_cnt),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][6:0] prog;
    logic [7:0][7:0] resp;
    logic [2:0]      last;
    logic [3:0]      rdly;
    logic [7:0]      exp_res;
    logic [3:0]      exp_zero;
  } vec_t;

  vec_t vt [4];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_hs   = 0;
  int   n_done = 0;

  always @(posedge clk) begin
    if (u_if.op_valid && u_if.op_ready) n_hs <= n_hs + 1;
    if (done) n_done <= n_done + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_prog(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 3'(i);
      prog_data = v.prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic exec(input vec_t v);
    int hs0;
    int d0;
    int t;
    hs0 = n_hs;
    d0  = n_done;
    @(negedge clk);
    start     = 1'b1;
    prog_last = v.last;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int k = 0; k <= int'(v.last); k++) begin
      t = 0;
      while (!u_if.op_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("op_valid", u_if.op_valid, 1);
      chk("op_func", u_if.op_func, v.prog[k][6:4]);
      chk("op_a", u_if.op_a, v.prog[k][3:0]);
      for (int d = 0; d < int'(v.rdly); d++) begin
        @(negedge clk);
        chk("stall_valid", u_if.op_valid, 1);
        chk("stall_func", u_if.op_func, v.prog[k][6:4]);
        chk("stall_a", u_if.op_a, v.prog[k][3:0]);
      end
      u_if.op_ready = 1'b1;
      @(negedge clk);
      u_if.op_ready = 1'b0;
      chk("wait_valid", u_if.op_valid, 0);
      u_if.res_valid = 1'b1;
      u_if.res_data  = v.resp[k];
      @(negedge clk);
      u_if.res_valid = 1'b0;
    end
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("busy_idle", busy, 0);
    chk("result", result, v.exp_res);
    chk("zero_cnt", zero_cnt, v.exp_zero);
    chk("handshakes", 32'(n_hs - hs0), 32'(int'(v.last) + 1));
    chk("done_count", 32'(n_done - d0), 1);
  endtask

  initial begin
    int d0;
    int hs0;
    int j;
    reset = 1'b1; prog_we = 1'b0; start = 1'b0;
    prog_addr = '0; prog_data = '0; prog_last = '0;
    u_if.op_ready = 1'b0; u_if.res_valid = 1'b0; u_if.res_data = '0;

    vt[0] = '0;
    vt[0].prog[0] = 7'b110_0011; vt[0].prog[1] = 7'b111_0000; vt[0].prog[2] = 7'b000_0010;
    vt[0].resp[0] = 8'h05; vt[0].resp[1] = 8'h06; vt[0].resp[2] = 8'h0A;
    vt[0].last = 3'd2; vt[0].rdly = 4'd0; vt[0].exp_res = 8'h0A; vt[0].exp_zero = 4'd0;

    vt[1] = '0;
    vt[1].prog[0] = 7'b011_1010; vt[1].resp[0] = 8'h33;
    vt[1].last = 3'd0; vt[1].rdly = 4'd5; vt[1].exp_res = 8'h33; vt[1].exp_zero = 4'd0;

    vt[2] = '0;
    for (int i = 0; i < 8; i++) vt[2].prog[i] = {3'(i), 4'(15 - i)};
    vt[2].last = 3'd7; vt[2].rdly = 4'd0; vt[2].exp_res = 8'h00; vt[2].exp_zero = 4'd8;

    vt[3] = '0;
    vt[3].prog[0] = 7'b101_0101; vt[3].prog[1] = 7'b010_1010;
    vt[3].prog[2] = 7'b001_1111; vt[3].prog[3] = 7'b100_0001;
    vt[3].resp[0] = 8'h00; vt[3].resp[1] = 8'h01; vt[3].resp[2] = 8'h00; vt[3].resp[3] = 8'hFF;
    vt[3].last = 3'd3; vt[3].rdly = 4'd1; vt[3].exp_res = 8'hFF; vt[3].exp_zero = 4'd2;

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", u_if.op_valid, 0);
    chk("rst_func", u_if.op_func, 0);
    chk("rst_a", u_if.op_a, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero_cnt, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      load_prog(vt[i]);
      exec(vt[i]);
    end

    // Reset while waiting for a result; program memory must survive.
    @(negedge clk);
    start = 1'b1; prog_last = vt[3].last;
    @(negedge clk);
    start = 1'b0; u_if.op_ready = 1'b1;
    @(negedge clk);
    u_if.op_ready = 1'b0;
    chk("mid_wait_busy", busy, 1);
    d0 = n_done;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_valid", u_if.op_valid, 0);
    chk("arst_func", u_if.op_func, 0);
    chk("arst_a", u_if.op_a, 0);
    chk("arst_result", result, 0);
    chk("arst_zero", zero_cnt, 0);
    chk("arst_error", error, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", 32'(n_done - d0), 0);
    exec(vt[3]);

    // res_valid in IDLE is ignored.
    @(negedge clk);
    u_if.res_valid = 1'b1; u_if.res_data = 8'h00;
    @(negedge clk);
    u_if.res_valid = 1'b0;
    chk("idle_res_result", result, 8'hFF);
    chk("idle_res_zero", zero_cnt, 2);
    chk("idle_res_busy", busy, 0);

    // Write and start together; then busy-time write/start/res_valid are ignored.
    hs0 = n_hs;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 7'b010_0001; start = 1'b1; prog_last = 3'd0;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    chk("wr_start_valid", u_if.op_valid, 1);
    chk("wr_start_func", u_if.op_func, 3'b010);
    chk("wr_start_a", u_if.op_a, 4'b0001);
    prog_we = 1'b1; prog_data = 7'b111_1111; start = 1'b1; prog_last = 3'd3;
    u_if.res_valid = 1'b1; u_if.res_data = 8'h00;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0; u_if.res_valid = 1'b0;
    chk("busy_wr_func", u_if.op_func, 3'b010);
    chk("busy_wr_a", u_if.op_a, 4'b0001);
    chk("issue_res_zero", zero_cnt, 0);
    u_if.op_ready = 1'b1;
    @(negedge clk);
    u_if.op_ready = 1'b0;
    u_if.res_valid = 1'b1; u_if.res_data = 8'h80;
    @(negedge clk);
    u_if.res_valid = 1'b0;
    chk("wr_start_done", done, 1);
    @(negedge clk);
    chk("wr_start_result", result, 8'h80);
    chk("wr_start_hs", 32'(n_hs - hs0), 1);
    start = 1'b1; prog_last = 3'd0;
    @(negedge clk);
    start = 1'b0;
    chk("mem_kept_func", u_if.op_func, 3'b010);
    chk("mem_kept_a", u_if.op_a, 4'b0001);

    // Handshake, then no result.
    u_if.op_ready = 1'b1;
    @(negedge clk);
    u_if.op_ready = 1'b0;
    d0 = n_done;
`ifdef ALU_SEQ_TIMEOUT_EN
    j = 0;
    while (!done && j < 40) begin
      @(negedge clk);
      j++;
    end
    chk("tmo_cycles", 32'(j), 15);
    chk("tmo_error", error, 1);
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_sticky", error, 1);
    chk("tmo_done_count", 32'(n_done - d0), 1);
    start = 1'b1; prog_last = 3'd0;
    @(negedge clk);
    start = 1'b0;
    chk("tmo_err_clear", error, 0);
    u_if.op_ready = 1'b1;
    @(negedge clk);
    u_if.op_ready = 1'b0;
`else
    j = 0;
    repeat (100) @(negedge clk);
    chk("hang_busy", busy, 1);
    chk("hang_no_done", 32'(n_done - d0), 0);
    chk("hang_error", error, 0);
`endif
    u_if.res_valid = 1'b1; u_if.res_data = 8'h11;
    @(negedge clk);
    u_if.res_valid = 1'b0;
    chk("final_done", done, 1);
    @(negedge clk);
    chk("final_result", result, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
